seg_hex595_chain: RTL and testbench

//  Parametrised multiplexed hex 7-segment driver for a 74HC595 chain (segment byte + digit-select byte).

---
 rtl/seg_hex595_chain.sv | 198 +++++++++++++++++++
 tb/tb_seg_hex595_chain.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_hex595_chain.sv
// Multiplexed hex 7-segment driver shifting {segment byte, digit-select byte}
// into a 74HC595 chain, one digit per scan slot, with frame-coherent inputs.
module seg_hex595_chain #(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 2000,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [4*NUM_DIGITS-1:0] hex_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic                    seg_clk,
  output logic                    seg_dat,
  output logic                    seg_str,
  output logic                    frame_done
);

  localparam int IDX_W  = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int DIV_W  = (CLK_DIV     > 1) ? $clog2(CLK_DIV)     : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {LOAD, SHIFT_LO, SHIFT_HI, STROBE, HOLD} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [DIV_W-1:0]        div_cnt, div_next;
  logic [HOLD_W-1:0]       hold_cnt, hold_next;
  logic [3:0]              bit_cnt, bit_next;
  logic [15:0]             word, word_next;
  logic [4*NUM_DIGITS-1:0] snap_hex, snap_hex_next;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_next;
  logic [NUM_DIGITS-1:0]   snap_blank, snap_blank_next;
  logic                    snap_lz, snap_lz_next;
  logic                    clk_next, dat_next, str_next, frame_next;

  logic [4*NUM_DIGITS-1:0] src_hex;
  logic [NUM_DIGITS-1:0]   src_dp, src_blank;
  logic                    src_lz;
  logic [3:0]              nib;
  logic                    upper_zero, blanked;
  logic [7:0]              seg_raw, seg_byte, sel_raw, sel_byte;
  logic                    div_last, hold_last, idx_last;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  assign div_last  = (div_cnt  == DIV_W'(CLK_DIV - 1));
  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign idx_last  = (idx      == IDX_W'(NUM_DIGITS - 1));

  // Digit 0 reads the live inputs because its LOAD is also the snapshot cycle.
  always_comb begin
    src_hex    = (idx == '0) ? hex_data   : snap_hex;
    src_dp     = (idx == '0) ? dp_mask    : snap_dp;
    src_blank  = (idx == '0) ? blank_mask : snap_blank;
    src_lz     = (idx == '0) ? lz_en      : snap_lz;
    nib        = src_hex[4*int'(idx) +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && src_hex[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blanked  = src_blank[idx] | (src_lz & (idx != '0) & upper_zero);
    seg_raw  = blanked ? 8'h00 : {src_dp[idx], hex_font(nib)};
    seg_byte = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
    sel_raw  = 8'd1 << idx;
    sel_byte = (DIG_ACT_LOW != 0) ? ~sel_raw : sel_raw;
  end

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    div_next        = div_cnt;
    hold_next       = hold_cnt;
    bit_next        = bit_cnt;
    word_next       = word;
    snap_hex_next   = snap_hex;
    snap_dp_next    = snap_dp;
    snap_blank_next = snap_blank;
    snap_lz_next    = snap_lz;
    frame_next      = 1'b0;
    case (state)
      LOAD: begin
        word_next  = {seg_byte, sel_byte};
        bit_next   = 4'd15;
        div_next   = '0;
        state_next = SHIFT_LO;
        if (idx == '0) begin
          snap_hex_next   = hex_data;
          snap_dp_next    = dp_mask;
          snap_blank_next = blank_mask;
          snap_lz_next    = lz_en;
        end
      end
      SHIFT_LO: begin
        div_next = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_next   = '0;
          state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        div_next = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_next = '0;
          if (bit_cnt == 4'd0) begin
            state_next = STROBE;
          end else begin
            bit_next   = bit_cnt - 4'd1;
            state_next = SHIFT_LO;
          end
        end
      end
      STROBE: begin
        div_next = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_next   = '0;
          hold_next  = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        hold_next = hold_cnt + HOLD_W'(1);
        if (hold_last) begin
          hold_next  = '0;
          state_next = LOAD;
          if (idx_last) begin
            idx_next   = '0;
            frame_next = 1'b1;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      default: state_next = LOAD;
    endcase
    // Pin values are registered from the next state so they never glitch.
    clk_next = (state_next == SHIFT_HI);
    str_next = (state_next == STROBE);
    dat_next = (state_next == SHIFT_LO || state_next == SHIFT_HI) ? word_next[bit_next] : 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= LOAD;
      idx        <= '0;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      snap_hex   <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
      seg_clk    <= 1'b0;
      seg_dat    <= 1'b0;
      seg_str    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      div_cnt    <= div_next;
      hold_cnt   <= hold_next;
      bit_cnt    <= bit_next;
      word       <= word_next;
      snap_hex   <= snap_hex_next;
      snap_dp    <= snap_dp_next;
      snap_blank <= snap_blank_next;
      snap_lz    <= snap_lz_next;
      seg_clk    <= clk_next;
      seg_dat    <= dat_next;
      seg_str    <= str_next;
      frame_done <= frame_next;
    end
  end

endmodule

// File: tb/tb_seg_hex595_chain.sv
// Bench for seg_hex595_chain: a behavioural 595 captures each strobed word
// from a 4-digit active-low-segment instance and an 8-digit active-low-select one.
module tb_seg_hex595_chain;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] hex_a = '0;
  logic [3:0]  dp_a = '0, blank_a = '0;
  logic        lz_a = 1'b0;
  logic [31:0] hex_b = '0;
  logic [7:0]  dp_b = '0, blank_b = '0;
  logic        lz_b = 1'b0;
  logic        seg_clk_a, seg_dat_a, seg_str_a, frame_done_a;
  logic        seg_clk_b, seg_dat_b, seg_str_b, frame_done_b;

  int passed = 0;
  int total  = 0;

  logic [15:0] sh_a = '0, sh_b = '0;
  logic [15:0] words_a[$];
  logic [15:0] words_b[$];

  typedef struct {
    string       name;
    bit          use_b;
    logic [31:0] hex;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        lz;
    int          digit;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 sys_clk = ~sys_clk;

  seg_hex595_chain #(.NUM_DIGITS(4), .CLK_DIV(2), .HOLD_CYCLES(4),
                     .SEG_ACT_LOW(1), .DIG_ACT_LOW(0)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .hex_data(hex_a), .dp_mask(dp_a),
    .blank_mask(blank_a), .lz_en(lz_a), .seg_clk(seg_clk_a), .seg_dat(seg_dat_a),
    .seg_str(seg_str_a), .frame_done(frame_done_a));

  seg_hex595_chain #(.NUM_DIGITS(8), .CLK_DIV(2), .HOLD_CYCLES(4),
                     .SEG_ACT_LOW(0), .DIG_ACT_LOW(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .hex_data(hex_b), .dp_mask(dp_b),
    .blank_mask(blank_b), .lz_en(lz_b), .seg_clk(seg_clk_b), .seg_dat(seg_dat_b),
    .seg_str(seg_str_b), .frame_done(frame_done_b));

  // Behavioural 74HC595 pair: shift on SHCP rise, latch on STCP rise.
  always @(posedge seg_clk_a) sh_a <= {sh_a[14:0], seg_dat_a};
  always @(posedge seg_clk_b) sh_b <= {sh_b[14:0], seg_dat_b};
  always @(posedge seg_str_a) words_a.push_back(sh_a);
  always @(posedge seg_str_b) words_b.push_back(sh_b);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic reportTimeout(input string name);
    total++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic applyStimulus(input logic [31:0] hex, input logic [7:0] dp,
                               input logic [7:0] blank, input logic lz);
    sys_rst = 1'b1;
    hex_a = hex[15:0]; dp_a = dp[3:0]; blank_a = blank[3:0]; lz_a = lz;
    hex_b = hex;       dp_b = dp;      blank_b = blank;      lz_b = lz;
    repeat (2) @(negedge sys_clk);
    words_a.delete();
    words_b.delete();
    sys_rst = 1'b0;
  endtask

  task automatic waitWords(input bit use_b, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((use_b ? words_b.size() : words_a.size()) >= n) begin
        ok = 1'b1;
        return;
      end
      @(negedge sys_clk);
    end
  endtask

  initial begin
    bit ok;
    int str_stamp[$];
    int fd_stamp[$];
    bit prev_str, prev_fd, fd_wide;
    logic [15:0] exp4[8];

    vecs.push_back('{"zero d0",      0, 32'h0000, 8'h00, 8'h00, 1'b0, 0, 16'hC001});
    vecs.push_back('{"zero d3",      0, 32'h0000, 8'h00, 8'h00, 1'b0, 3, 16'hC008});
    vecs.push_back('{"lz d3",        0, 32'h00A5, 8'h00, 8'h00, 1'b1, 3, 16'hFF08});
    vecs.push_back('{"lz d2",        0, 32'h00A5, 8'h00, 8'h00, 1'b1, 2, 16'hFF04});
    vecs.push_back('{"lz d1",        0, 32'h00A5, 8'h00, 8'h00, 1'b1, 1, 16'h8802});
    vecs.push_back('{"lz d0",        0, 32'h00A5, 8'h00, 8'h00, 1'b1, 0, 16'h9201});
    vecs.push_back('{"dp d0",        0, 32'h1234, 8'h01, 8'h04, 1'b0, 0, 16'h1901});
    vecs.push_back('{"mask d1",      0, 32'h1234, 8'h01, 8'h04, 1'b0, 1, 16'hB002});
    vecs.push_back('{"blank d2",     0, 32'h1234, 8'h01, 8'h04, 1'b0, 2, 16'hFF04});
    vecs.push_back('{"mask d3",      0, 32'h1234, 8'h01, 8'h04, 1'b0, 3, 16'hF908});
    vecs.push_back('{"lz beats dp",  0, 32'h0005, 8'h08, 8'h00, 1'b1, 3, 16'hFF08});
    vecs.push_back('{"lz keeps d0",  0, 32'h0000, 8'h00, 8'h00, 1'b1, 0, 16'hC001});
    vecs.push_back('{"inner zero",   0, 32'h0500, 8'h00, 8'h00, 1'b1, 1, 16'hC002});
    vecs.push_back('{"b d7",         1, 32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 7, 16'h717F});
    vecs.push_back('{"b d3",         1, 32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 3, 16'h7CF7});
    vecs.push_back('{"b d0",         1, 32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 0, 16'h7FFE});

    // Reset state with the clock running.
    repeat (3) @(negedge sys_clk);
    checkOutput("reset pins a", {28'h0, seg_clk_a, seg_dat_a, seg_str_a, frame_done_a}, 32'h0);
    checkOutput("reset pins b", {28'h0, seg_clk_b, seg_dat_b, seg_str_b, frame_done_b}, 32'h0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].hex, vecs[k].dp, vecs[k].blank, vecs[k].lz);
      waitWords(vecs[k].use_b, vecs[k].digit + 1, 1500, ok);
      if (!ok) reportTimeout(vecs[k].name);
      else checkOutput(vecs[k].name,
                       vecs[k].use_b ? words_b[vecs[k].digit] : words_a[vecs[k].digit],
                       vecs[k].exp);
    end

    // Digit period, frame period and frame_done pulse width.
    applyStimulus(32'h0, 8'h0, 8'h0, 1'b0);
    prev_str = 1'b0; prev_fd = 1'b0; fd_wide = 1'b0;
    for (int n = 0; n < 1200 && fd_stamp.size() < 2; n++) begin
      @(negedge sys_clk);
      if (seg_str_a && !prev_str) str_stamp.push_back(n);
      if (frame_done_a) begin
        if (prev_fd) fd_wide = 1'b1;
        else fd_stamp.push_back(n);
      end
      prev_str = seg_str_a;
      prev_fd  = frame_done_a;
    end
    if (str_stamp.size() < 5 || fd_stamp.size() < 2) begin
      reportTimeout("period capture");
    end else begin
      checkOutput("digit period", str_stamp[1] - str_stamp[0], 71);
      checkOutput("four digits", str_stamp[4] - str_stamp[0], 284);
      checkOutput("frame_done period", fd_stamp[1] - fd_stamp[0], 284);
      checkOutput("frame_done width", {31'h0, fd_wide}, 0);
    end

    // Input change during digit 1 must not tear the current frame.
    exp4 = '{16'hF901, 16'hF902, 16'hF904, 16'hF908, 16'hA401, 16'hA402, 16'hA404, 16'hA408};
    applyStimulus(32'h1111, 8'h0, 8'h0, 1'b0);
    waitWords(1'b0, 1, 400, ok);
    if (!ok) reportTimeout("tear start");
    else begin
      repeat (10) @(negedge sys_clk);
      hex_a = 16'h2222;
      waitWords(1'b0, 8, 1000, ok);
      if (!ok) reportTimeout("tear frames");
      else for (int i = 0; i < 8; i++) checkOutput($sformatf("tear word %0d", i), words_a[i], exp4[i]);
    end

    // Async reset in the middle of a high shift-clock phase.
    applyStimulus(32'h1234, 8'h0, 8'h0, 1'b0);
    waitWords(1'b0, 1, 400, ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge sys_clk);
      if (seg_clk_a) ok = 1'b1;
    end
    if (!ok) reportTimeout("find SHIFT_HI");
    else begin
      sys_rst = 1'b1;
      #1;
      checkOutput("async seg_clk", {31'h0, seg_clk_a}, 0);
      checkOutput("async seg_dat", {31'h0, seg_dat_a}, 0);
      checkOutput("async seg_str", {31'h0, seg_str_a}, 0);
      @(negedge sys_clk);
      words_a.delete();
      sys_rst = 1'b0;
      waitWords(1'b0, 1, 400, ok);
      if (!ok) reportTimeout("post-reset word");
      else checkOutput("post-reset digit0", words_a[0], 16'h9901);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
